// File: rtl/fifo_pop_checker.sv
// Read-side FIFO consumer that pops words, optionally throttled by an LFSR,
// and checks them against an incrementing sequence, reporting counts and first error.
module fifo_pop_checker #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] START_VALUE,
    input  logic [CNT_WIDTH-1:0]  TOTAL,
    input  logic                  THROTTLE,
    output logic                  R_nEN,
    input  logic [DATA_WIDTH-1:0] R_DATA,
    input  logic                  R_EMPTY,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS,
    output logic                  TIMEOUT,
    output logic [CNT_WIDTH-1:0]  RD_CNT,
    output logic [CNT_WIDTH-1:0]  ERR_CNT,
    output logic [DATA_WIDTH-1:0] ERR_DATA,
    output logic [DATA_WIDTH-1:0] ERR_EXP
);

    localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] expected_q, expected_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0]  total_q, total_d;
    logic [DATA_WIDTH-1:0] err_data_q, err_data_d;
    logic [DATA_WIDTH-1:0] err_exp_q, err_exp_d;
    logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic                  throttle_q, throttle_d;
    logic                  timeout_q, timeout_d;

    logic                  pop;
    logic [CNT_WIDTH-1:0]  rd_cnt_inc;
    logic                  lfsr_fb;

    // Pop is gated on !R_EMPTY so the request never asserts against an empty FIFO.
    assign pop        = (state_q == S_RUN) && !R_EMPTY && (!throttle_q || lfsr_q[0]);
    assign rd_cnt_inc = rd_cnt_q + CNT_WIDTH'(1);
    assign lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        rd_cnt_d   = rd_cnt_q;
        err_cnt_d  = err_cnt_q;
        total_d    = total_q;
        err_data_d = err_data_q;
        err_exp_d  = err_exp_q;
        idle_cnt_d = idle_cnt_q;
        lfsr_d     = lfsr_q;
        throttle_d = throttle_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    expected_d = START_VALUE;
                    rd_cnt_d   = '0;
                    err_cnt_d  = '0;
                    err_data_d = '0;
                    err_exp_d  = '0;
                    idle_cnt_d = '0;
                    timeout_d  = 1'b0;
                    lfsr_d     = SEED;
                    throttle_d = THROTTLE;
                    total_d    = TOTAL;
                    state_d    = (TOTAL == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                lfsr_d = {lfsr_fb, lfsr_q[15:1]};
                if (pop) begin
                    rd_cnt_d   = rd_cnt_inc;
                    idle_cnt_d = '0;
                    // Resync to the received word so a drop or duplicate costs one error.
                    expected_d = R_DATA + DATA_WIDTH'(1);
                    if (R_DATA != expected_q) begin
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                        if (err_cnt_q == '0) begin
                            err_data_d = R_DATA;
                            err_exp_d  = expected_q;
                        end
                    end
                    if (rd_cnt_inc == total_q) state_d = S_DONE;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            expected_q <= '0;
            rd_cnt_q   <= '0;
            err_cnt_q  <= '0;
            total_q    <= '0;
            err_data_q <= '0;
            err_exp_q  <= '0;
            idle_cnt_q <= '0;
            lfsr_q     <= SEED;
            throttle_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            rd_cnt_q   <= rd_cnt_d;
            err_cnt_q  <= err_cnt_d;
            total_q    <= total_d;
            err_data_q <= err_data_d;
            err_exp_q  <= err_exp_d;
            idle_cnt_q <= idle_cnt_d;
            lfsr_q     <= lfsr_d;
            throttle_q <= throttle_d;
            timeout_q  <= timeout_d;
        end
    end

    assign R_nEN    = !pop;
    assign BUSY     = (state_q == S_RUN);
    assign DONE     = (state_q == S_DONE);
    assign PASS     = DONE && (err_cnt_q == '0) && !timeout_q;
    assign TIMEOUT  = timeout_q;
    assign RD_CNT   = rd_cnt_q;
    assign ERR_CNT  = err_cnt_q;
    assign ERR_DATA = err_data_q;
    assign ERR_EXP  = err_exp_q;

endmodule

// File: tb/tb_fifo_pop_checker.sv
// Directed bench for fifo_pop_checker: behavioural show-ahead FIFO on the read port,
// hand-computed expectations and an independent reference LFSR for throttled runs.
module tb_fifo_pop_checker;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [31:0] start_value;
    logic [15:0] total;
    logic        throttle;
    logic        r_nen;
    logic [31:0] r_data;
    logic        r_empty;
    logic        busy, done, pass, timeout;
    logic [15:0] rd_cnt, err_cnt;
    logic [31:0] err_data, err_exp;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:63];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;

    fifo_pop_checker #(
        .DATA_WIDTH(32),
        .CNT_WIDTH(16),
        .TIMEOUT_CYCLES(16),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .CLK(clk), .nRST(nrst), .START(start), .START_VALUE(start_value),
        .TOTAL(total), .THROTTLE(throttle), .R_nEN(r_nen), .R_DATA(r_data),
        .R_EMPTY(r_empty), .BUSY(busy), .DONE(done), .PASS(pass),
        .TIMEOUT(timeout), .RD_CNT(rd_cnt), .ERR_CNT(err_cnt),
        .ERR_DATA(err_data), .ERR_EXP(err_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign r_empty = (rd_ptr == wr_ptr);
    assign r_data  = mem[rd_ptr % 64];

    always @(posedge clk) if (!r_nen) rd_ptr <= rd_ptr + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        mem[wr_ptr % 64] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_start(input logic [31:0] sv, input logic [15:0] tot, input logic thr);
        @(negedge clk);
        start = 1'b1; start_value = sv; total = tot; throttle = thr;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 1'b1);
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] l);
        logic b;
        b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
        return (l >> 1) | (16'(b) << 15);
    endfunction

    logic        pat [0:255];
    int          n1, n2;
    logic [15:0] ref_l;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; start = 1'b0; start_value = '0; total = '0; throttle = 1'b0;
        #12;
        chk("rst_rnen", r_nen, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_rdcnt", rd_cnt, 16'd0);
        @(negedge clk);
        nrst = 1'b1;

        // Clean run 0..4, back-to-back pops.
        for (int i = 0; i < 5; i++) push(32'(i));
        do_start(32'd0, 16'd5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("basic_rnen_low", r_nen, 1'b0);
            @(negedge clk);
        end
        chk("basic_done", done, 1'b1);
        chk("basic_rnen_after", r_nen, 1'b1);
        chk("basic_rdcnt", rd_cnt, 16'd5);
        chk("basic_errcnt", err_cnt, 16'd0);
        chk("basic_pass", pass, 1'b1);

        // Skipped word 3: one error, capture 4 vs 3.
        push(32'd0); push(32'd1); push(32'd2); push(32'd4); push(32'd5);
        do_start(32'd0, 16'd5, 1'b0);
        wait_done("err_wait");
        chk("err_errcnt", err_cnt, 16'd1);
        chk("err_data", err_data, 32'd4);
        chk("err_exp", err_exp, 32'd3);
        chk("err_pass", pass, 1'b0);
        chk("err_rdcnt", rd_cnt, 16'd5);

        // Expected counter wraps through zero.
        push(32'hFFFF_FFFE); push(32'hFFFF_FFFF); push(32'd0); push(32'd1);
        do_start(32'hFFFF_FFFE, 16'd4, 1'b0);
        wait_done("wrap_wait");
        chk("wrap_errcnt", err_cnt, 16'd0);
        chk("wrap_pass", pass, 1'b1);
        chk("wrap_rdcnt", rd_cnt, 16'd4);

        // Starvation: two words then 16 pop-free cycles.
        push(32'd10); push(32'd11);
        do_start(32'd10, 16'd3, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("starve_rnen_empty", r_nen, 1'b1);
        for (int i = 0; i < 15; i++) @(negedge clk);
        chk("starve_busy_before", busy, 1'b1);
        chk("starve_to_before", timeout, 1'b0);
        @(negedge clk);
        chk("starve_done", done, 1'b1);
        chk("starve_timeout", timeout, 1'b1);
        chk("starve_rdcnt", rd_cnt, 16'd2);
        chk("starve_pass", pass, 1'b0);

        // TOTAL==0 completes immediately with PASS.
        do_start(32'd0, 16'd0, 1'b0);
        chk("zero_done", done, 1'b1);
        chk("zero_pass", pass, 1'b1);
        chk("zero_rdcnt", rd_cnt, 16'd0);
        chk("zero_timeout", timeout, 1'b0);

        // Throttled run, then identical rerun from DONE.
        for (int i = 0; i < 20; i++) push(32'(100 + i));
        do_start(32'd100, 16'd20, 1'b1);
        ref_l = 16'hACE1;
        n1 = 0;
        while (busy && n1 < 200) begin
            chk("thr_rnen", r_nen, !ref_l[0]);
            pat[n1] = r_nen;
            n1++;
            @(negedge clk);
            ref_l = ref_step(ref_l);
        end
        chk("thr_done", done, 1'b1);
        chk("thr_rdcnt", rd_cnt, 16'd20);
        chk("thr_pass", pass, 1'b1);

        for (int i = 0; i < 20; i++) push(32'(100 + i));
        do_start(32'd100, 16'd20, 1'b1);
        n2 = 0;
        while (busy && n2 < 200) begin
            if (n2 < n1) chk("rerun_rnen", r_nen, pat[n2]);
            n2++;
            @(negedge clk);
        end
        chk("rerun_len", 64'(n2), 64'(n1));
        chk("rerun_pass", pass, 1'b1);

        // Mid-run reset with a recorded error and FIFO still non-empty.
        push(32'd7); push(32'd9); push(32'd10); push(32'd11); push(32'd12);
        do_start(32'd7, 16'd10, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("mid_errcnt", err_cnt, 16'd1);
        chk("mid_rnen", r_nen, 1'b0);
        #1 nrst = 1'b0;
        #1;
        chk("mid_rst_rnen", r_nen, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_rdcnt", rd_cnt, 16'd0);
        chk("mid_rst_errcnt", err_cnt, 16'd0);
        chk("mid_rst_errdata", err_data, 32'd0);
        chk("mid_rst_errexp", err_exp, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        wr_ptr = rd_ptr;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_pop_checker.md
Name: fifo_pop_checker

Overview:
- Single-clock consumer/checker for the read side of a FIFO pop interface (R_nEN / R_DATA / R_EMPTY), the counterpart of the incrementing-data writer used in FIFO test DUTs.
- Pops words, with optional pseudo-random throttling, and checks them against an incrementing expected sequence.
- Reports read count, error count, first-error capture, timeout and pass/fail.
- Sits on the read clock domain, directly on a FiFo_Async / FiFo read port.

Parameters:
DATA_WIDTH, 32, width of R_DATA and of the expected-value counter
CNT_WIDTH, 16, width of TOTAL, RD_CNT, ERR_CNT
TIMEOUT_CYCLES, 1024, consecutive RUN cycles without a pop before timeout (>=2)
LFSR_SEED, 16'hACE1, throttle LFSR reset/start value; a value of 0 is replaced by 16'hACE1

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
START  input  1  single-cycle start pulse; accepted in IDLE or DONE only
START_VALUE  input  DATA_WIDTH  first expected word, sampled with START
TOTAL  input  CNT_WIDTH  number of words to pop, sampled with START
THROTTLE  input  1  1 = pop only when lfsr[0]=1, sampled with START
R_nEN  output  1  pop request, active low, to FIFO
R_DATA  input  DATA_WIDTH  FIFO head word, valid while R_EMPTY=0 (show-ahead)
R_EMPTY  input  1  FIFO empty
BUSY  output  1  state==RUN
DONE  output  1  state==DONE
PASS  output  1  DONE && ERR_CNT==0 && !TIMEOUT
TIMEOUT  output  1  run ended by timeout
RD_CNT  output  CNT_WIDTH  words popped in this run
ERR_CNT  output  CNT_WIDTH  mismatches, saturating at all-ones
ERR_DATA  output  DATA_WIDTH  R_DATA at first mismatch
ERR_EXP  output  DATA_WIDTH  expected value at first mismatch

Behaviour:
- Reset (async, nRST=0): state=IDLE, R_nEN=1, BUSY=0, DONE=0, PASS=0, TIMEOUT=0, RD_CNT=0, ERR_CNT=0, ERR_DATA=0, ERR_EXP=0, expected=0, idle_cnt=0, lfsr=LFSR_SEED. Reset mid-run aborts immediately with these values.
- States:
  - IDLE -> RUN on START.
  - RUN -> DONE on last pop or timeout.
  - DONE -> RUN on START. DONE and PASS are held until the next START.
- On START: load expected=START_VALUE; clear RD_CNT, ERR_CNT, ERR_DATA, ERR_EXP, TIMEOUT, idle_cnt; lfsr=LFSR_SEED; latch THROTTLE.
- START with TOTAL==0: go straight to DONE with PASS=1 and zero pops.
- R_nEN is combinational: R_nEN = !(state==RUN && !R_EMPTY && (!throttle_q || lfsr[0])). It never goes low while R_EMPTY=1.
- A pop completes on each rising edge where R_nEN=0. Zero-latency data: compare R_DATA against expected in the same cycle.
- On each pop:
  - RD_CNT += 1.
  - On mismatch, ERR_CNT += 1 (saturating). If ERR_CNT was 0, also capture ERR_DATA=R_DATA and ERR_EXP=expected.
  - expected <= R_DATA + 1, modulo 2^DATA_WIDTH (resync, so a drop or duplicate costs one error). all-ones+1 wraps to 0 with no error.
- Last pop (RD_CNT+1 == TOTAL): go to DONE at that edge. R_nEN is 1 from the next cycle.
- Timeout: idle_cnt clears on a pop and increments on every other RUN cycle. When idle_cnt == TIMEOUT_CYCLES-1 and no pop occurs, go to DONE with TIMEOUT=1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It shifts every RUN cycle regardless of pop and holds in IDLE/DONE.
- START while in RUN is ignored.

Test Plan:
- Reset: nRST low mid-RUN -> same cycle R_nEN=1, BUSY=0, DONE=0, all counters and captures 0.
- START_VALUE=0, TOTAL=5, THROTTLE=0, FIFO preloaded 0..4 -> R_nEN low for 5 consecutive cycles, RD_CNT=5, DONE=1, PASS=1, ERR_CNT=0.
- FIFO data 0,1,2,4,5, TOTAL=5 -> ERR_CNT=1, ERR_DATA=4, ERR_EXP=3, PASS=0, RD_CNT=5.
- Wrap: START_VALUE=32'hFFFF_FFFE, data FFFF_FFFE, FFFF_FFFF, 0, 1, TOTAL=4 -> ERR_CNT=0, PASS=1.
- Starvation: TOTAL=3, TIMEOUT_CYCLES=16, only 2 words ever written -> R_nEN stays 1 while empty, TIMEOUT=1 after 16 pop-free cycles, RD_CNT=2, PASS=0.
- Throttle: THROTTLE=1, TOTAL=20, FIFO kept non-empty -> pops only on cycles where the reference LFSR bit0=1, RD_CNT=20, PASS=1. A second START from DONE reruns with identical R_nEN timing.
